// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: machine word, IF/ID buffer entry, fetch FSM states.
package riscv_pkg;

  typedef logic [31:0] word_t;

  // One IF/ID buffer slot: the fetched instruction and the address it came from.
  typedef struct packed {
    word_t inst;
    word_t pc;
  } fetch_entry_t;

  localparam word_t NOP_INST         = 32'h0000_0013;  // addi x0,x0,0
  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: instruction-memory request/response, EX redirect, and IF/ID handshake.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;
  logic  redirect;
  word_t redirect_pc;
  logic  id_valid;
  logic  id_ready;
  word_t id_inst;
  word_t id_pc;
  word_t id_pc_plus4;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  // Memory / EX / decode side.
  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; clear beats push/pop, head is the oldest entry.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop_ok;

  assign empty  = (count == '0);
  assign pop_ok = pop && !empty;
  assign head   = mem[rd_ptr];

  // Storage write; slots are only ever read once count marks them live.
  // NOTE: the data array has no reset -- clearing the pointers and count is what empties the FIFO.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, issues credit-limited in-order word reads,
// buffers responses for decode and squashes in-flight fetches on redirect.
module fetch_stage
  import riscv_pkg::word_t;
  import riscv_pkg::fetch_entry_t;
  import riscv_pkg::fetch_state_e;
  import riscv_pkg::S_BOOT;
  import riscv_pkg::S_RUN;
  import riscv_pkg::S_FLUSH;
#(
  parameter word_t RESET_PC   = riscv_pkg::RESET_PC_DEFAULT,
  parameter int    FIFO_DEPTH = 2,
  parameter word_t NOP_INST   = riscv_pkg::NOP_INST
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  word_t         pc;
  word_t         req_pc;       // PC of the single request awaiting its response
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  logic [CW:0]   credit_sum;
  logic [CW-1:0] flush_left;
  logic          req;
  logic          grant;
  logic          resp_live;
  logic          resp_drop;
  logic          push;
  logic          pop;
  word_t         head_pc;

  // Request credit, response routing and decode pop; redirect wins over everything.
  // NOTE: every signal gets a value on every path here, so no latch can be inferred.
  always_comb begin
    credit_sum = {1'b0, fifo_count} + {1'b0, outstanding};
    req        = (state == S_RUN) && !bus.redirect &&
                 (credit_sum < (CW+1)'(FIFO_DEPTH));
    grant      = req && bus.imem_gnt;
    // A response with nothing outstanding belongs to a pre-reset request.
    resp_live  = bus.imem_rvalid && (outstanding != '0);
    resp_drop  = resp_live && (drop_cnt != '0);
    push       = resp_live && (drop_cnt == '0) && !bus.redirect;
    pop        = !fifo_empty && bus.id_ready && !bus.redirect;
    flush_left = outstanding - CW'(resp_live);
    push_data  = '{inst: bus.imem_rdata, pc: req_pc};
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign head_pc         = fifo_empty ? RESET_PC : head.pc;
  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.id_valid    = !fifo_empty;
  assign bus.id_inst     = fifo_empty ? NOP_INST : head.inst;
  assign bus.id_pc       = head_pc;
  assign bus.id_pc_plus4 = head_pc + 32'd4;

  // Fetch FSM with PC, request shadow and in-flight/drop counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_BOOT;
      pc          <= {RESET_PC[31:2], 2'b00};
      req_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (grant) req_pc <= pc;
      if (bus.redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        pc          <= bus.redirect_pc & ~32'h3;
        outstanding <= flush_left;
        drop_cnt    <= flush_left;
        state       <= (flush_left != '0) ? S_FLUSH : S_RUN;
      end else begin
        if (grant) pc <= pc + 32'd4;
        outstanding <= outstanding + CW'(grant) - CW'(resp_live);
        if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
        case (state)
          S_BOOT:  state <= S_RUN;
          S_FLUSH: if (drop_cnt == '0 || (resp_drop && drop_cnt == CW'(1))) state <= S_RUN;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: 1-cycle memory model, queue scoreboard,
// program-order tracker, directed scenarios and a randomized run.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int    DEPTH   = 2;
  localparam word_t XOR_KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC   (RESET_PC_DEFAULT),
    .FIFO_DEPTH (DEPTH),
    .NOP_INST   (NOP_INST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit    m_boot;
  word_t m_pc;
  int    m_out;
  int    m_drop;
  word_t m_q[$];
  bit    mem_pend;
  word_t mem_addr;
  word_t next_id_pc;
  int    cyc;
  int    first_valid_cyc;
  int    dut_grants;
  bit    watch_first;
  word_t first_pc;
  word_t wrap_plus4;

  task automatic model_reset();
    m_boot          = 1'b1;
    m_pc            = RESET_PC_DEFAULT;
    m_out           = 0;
    m_drop          = 0;
    m_q.delete();
    mem_pend        = 1'b0;
    mem_addr        = '0;
    next_id_pc      = RESET_PC_DEFAULT;
    cyc             = 0;
    first_valid_cyc = -1;
  endtask

  task automatic quiet_inputs();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},    32'(bus.imem_req), 32'd0);
    check({tag, "_id_valid"},    32'(bus.id_valid), 32'd0);
    check({tag, "_id_inst"},     bus.id_inst,       NOP_INST);
    check({tag, "_id_pc"},       bus.id_pc,         RESET_PC_DEFAULT);
    check({tag, "_id_pc_plus4"}, bus.id_pc_plus4,   RESET_PC_DEFAULT + 32'd4);
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance the model.
  task automatic step(input bit gnt, input bit ready, input bit redir, input word_t rpc);
    bit    exp_req;
    bit    exp_valid;
    bit    resp;
    bit    granted;
    word_t fetch_pc;
    @(negedge clk);
    bus.imem_gnt    = gnt;
    bus.id_ready    = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_rvalid = mem_pend;
    bus.imem_rdata  = mem_pend ? (mem_addr ^ XOR_KEY) : word_t'($urandom);
    #1;
    exp_req = !m_boot && (m_drop == 0) && !redir && (m_q.size() + m_out < DEPTH);
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
    exp_valid = (m_q.size() != 0);
    check("id_valid", 32'(bus.id_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("id_pc",       bus.id_pc,       m_q[0]);
      check("id_inst",     bus.id_inst,     m_q[0] ^ XOR_KEY);
      check("id_pc_plus4", bus.id_pc_plus4, m_q[0] + 32'd4);
    end else begin
      check("id_inst_nop", bus.id_inst, NOP_INST);
    end
    if (bus.id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.id_valid && bus.id_pc == 32'hFFFF_FFFC) wrap_plus4 = bus.id_pc_plus4;
    if (bus.imem_req && gnt) dut_grants++;

    granted  = exp_req && gnt;
    fetch_pc = m_pc;
    resp     = mem_pend && (m_out > 0);
    if (redir) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (resp) m_out--;
      m_drop      = m_out;
      next_id_pc  = m_pc;
      watch_first = 1'b1;
    end else begin
      if (exp_valid && ready) begin
        check("id_order", bus.id_pc, next_id_pc);
        if (watch_first) begin
          first_pc    = bus.id_pc;
          watch_first = 1'b0;
        end
        next_id_pc = next_id_pc + 32'd4;
        void'(m_q.pop_front());
      end
      if (resp) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else m_q.push_back(mem_addr);
      end
      if (granted) begin
        m_out++;
        m_pc = m_pc + 32'd4;
      end
    end
    m_boot   = 1'b0;
    mem_pend = granted;
    mem_addr = fetch_pc;
    cyc++;
  endtask

  // Credit rule must keep pushes out of a full buffer.
  always @(posedge clk) begin
    if (!reset && dut.push && !dut.pop && !bus.redirect && int'(dut.fifo_count) >= DEPTH) begin
      n_fail++;
      $display("FAIL fifo_overflow: count %0d with push and no pop (t=%0t)", dut.fifo_count, $time);
    end
  end

  initial begin
    quiet_inputs();
    reset = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();

    // Streaming with always-grant memory and ready decode
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("first_valid_cycle", 32'(first_valid_cyc), 32'd3);

    // Decode stall for 6 cycles, then release
    dut_grants = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
    check("stall_grants_bounded", 32'(dut_grants <= DEPTH), 32'd1);
    check("stall_req_dropped", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect to a misaligned target in steady state
    first_pc = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("first_pc_after_redirect", first_pc, 32'h0000_0100);

    // Back-to-back redirects
    first_pc = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("first_pc_after_double_redirect", first_pc, 32'h0000_0300);

    // PC wrap at 2^32
    wrap_plus4 = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("wrap_pc_plus4", wrap_plus4, 32'h0000_0000);

    // Randomized grants, stalls and redirects
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 40) == 0, word_t'($urandom));
    end

    // Fill the buffer, then assert reset between edges
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
    check("full_before_reset", 32'(bus.id_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    quiet_inputs();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("refetch_first_valid_cycle", 32'(first_valid_cyc), 32'd3);
    check("refetch_order_advanced", 32'(next_id_pc != RESET_PC_DEFAULT), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
